// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_gen_state_t;

    localparam logic [3:0] SEQ_PAT_0001 = 4'b0001;
    localparam logic       SEQ_IDLE_LVL = 1'b1;

endpackage

// File: rtl/seq_gen_shifter.sv
// Pattern shifter: walks bit_idx from PAT_W-1 down to 0 and registers the line bit.
// SEQ_GEN_0001_ERRINJ_EN adds a request to invert the bit 0 being advanced to.
module seq_gen_shifter
    import seq_gen_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PAT_0001
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic advance_i,
    input  logic clear_i,
`ifdef SEQ_GEN_0001_ERRINJ_EN
    input  logic flip_i,
    output logic flip_used_c,
`endif
    output logic bit_o,
    output logic last_o
);

    localparam int unsigned IDX_W = $clog2(PAT_W);

    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic             bit_q, bit_d;
    logic             last_q, last_d;
    logic             flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            bit_q  <= SEQ_IDLE_LVL;
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            bit_q  <= bit_d;
            last_q <= last_d;
        end
    end

    // Clear parks the line at idle level; load/advance select the next pattern bit.
    always_comb begin
        idx_d   = idx_q;
        bit_d   = bit_q;
        last_d  = last_q;
        nxt_idx = idx_q - IDX_W'(1);
        flip    = 1'b0;
`ifdef SEQ_GEN_0001_ERRINJ_EN
        flip        = flip_i && (nxt_idx == '0);
        flip_used_c = 1'b0;
`endif
        if (clear_i) begin
            idx_d  = '0;
            bit_d  = SEQ_IDLE_LVL;
            last_d = 1'b0;
        end else if (load_i) begin
            idx_d  = IDX_W'(PAT_W - 1);
            bit_d  = PATTERN[PAT_W-1];
            last_d = 1'b0;
        end else if (advance_i && (idx_q != '0)) begin
            idx_d  = nxt_idx;
            bit_d  = PATTERN[nxt_idx] ^ flip;
            last_d = (nxt_idx == '0);
`ifdef SEQ_GEN_0001_ERRINJ_EN
            flip_used_c = flip;
`endif
        end
    end

    assign bit_o  = bit_q;
    assign last_o = last_q;

endmodule

// File: rtl/seq_gen_0001.sv
// Serial pattern transmitter: sends N frames of PATTERN MSB first with idle-high gaps.
// Optional feature macro: SEQ_GEN_0001_ERRINJ_EN (adds err_inj one-shot bit-0 inversion).
module seq_gen_0001
    import seq_gen_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PAT_0001,
    parameter int unsigned      CNT_W   = 8,
    parameter int unsigned      GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_frames,
    input  logic [GAP_W-1:0] req_gap,
    input  logic             abort,
`ifdef SEQ_GEN_0001_ERRINJ_EN
    input  logic             err_inj,
`endif
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             frame_strobe
);

    seq_gen_state_t   state_q, state_d;
    logic [CNT_W-1:0] frames_left_q, frames_left_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_ready_q, req_ready_d;
    logic             sh_load, sh_adv, sh_clear;
    logic             sh_bit, sh_last;
    logic             hs;

    assign hs = req_valid && req_ready_q;

`ifdef SEQ_GEN_0001_ERRINJ_EN
    logic inj_armed_q, inj_eff, flip_used;

    // A pulse arriving while a bit 0 is being loaded is applied immediately.
    assign inj_eff = inj_armed_q | err_inj;

    always_ff @(posedge clk) begin
        if (rst) inj_armed_q <= 1'b0;
        else     inj_armed_q <= inj_eff & ~flip_used;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frames_left_q <= '0;
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            req_ready_q   <= req_ready_d;
        end
    end

    // Next state and counters; sh_last marks the cycle bit 0 is on the line.
    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        gap_len_d     = gap_len_q;
        gap_cnt_d     = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    frames_left_d = req_frames;
                    gap_len_d     = req_gap;
                    state_d       = (req_frames == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = DONE;
                end else if (sh_last) begin
                    if (frames_left_q != '0) frames_left_d = frames_left_q - CNT_W'(1);
                    if (frames_left_q <= CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q <= GAP_W'(1)) state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output look-ahead: registered outputs follow the state being entered.
    always_comb begin
        sh_clear    = (state_d != SEND);
        sh_load     = (state_d == SEND) && ((state_q != SEND) || sh_last);
        sh_adv      = (state_d == SEND) && (state_q == SEND) && !sh_last;
        busy_d      = (state_d == SEND) || (state_d == GAP);
        done_d      = (state_d == DONE);
        req_ready_d = (state_d == IDLE);
    end

    seq_gen_shifter #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sh_load),
        .advance_i   (sh_adv),
        .clear_i     (sh_clear),
`ifdef SEQ_GEN_0001_ERRINJ_EN
        .flip_i      (inj_eff),
        .flip_used_c (flip_used),
`endif
        .bit_o       (sh_bit),
        .last_o      (sh_last)
    );

    assign out          = sh_bit;
    assign frame_strobe = sh_last;
    assign busy         = busy_q;
    assign done         = done_q;
    assign req_ready    = req_ready_q;

endmodule

// File: tb/tb_seq_gen_0001.sv
// Scoreboard bench for seq_gen_0001: per-cycle expected line/flag values from a frame-level model.
module tb_seq_gen_0001;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 4;

    typedef struct {
        int frames;
        int gap;
        int abort_at;
        int inj_at;
        bit early;
    } req_t;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_frames;
    logic [GAP_W-1:0] req_gap;
    logic             abort;
    logic             err_inj;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic             frame_strobe;

    // Expected record per cycle: {out, frame_strobe, busy, done, req_ready}
    logic [4:0] exp_q[$];
    req_t       reqs[$];
    int         n_tests;
    int         n_fail;
    bit         mon_en;

    seq_gen_0001 #(
        .PAT_W   (PAT_W),
        .PATTERN (4'b0001),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_frames   (req_frames),
        .req_gap      (req_gap),
        .abort        (abort),
`ifdef SEQ_GEN_0001_ERRINJ_EN
        .err_inj      (err_inj),
`endif
        .out          (ser_out),
        .busy         (busy),
        .done         (done),
        .frame_strobe (frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Frame-level model: frames of the pattern, gap ones between, optional truncation and inversion.
    function automatic int build(input req_t r);
        logic [4:0]       tr[$];
        logic [PAT_W-1:0] pat;
        logic             v;
        int               flip_k;
        int               c0;
        pat    = 4'b0001;
        flip_k = -1;
        if (r.inj_at > 0) begin
            for (int k = 0; k < r.frames; k++) begin
                c0 = k * (int'(PAT_W) + r.gap) + int'(PAT_W);
                if (flip_k < 0 && c0 >= r.inj_at + 1) flip_k = k;
            end
        end
        for (int k = 0; k < r.frames; k++) begin
            for (int b = int'(PAT_W) - 1; b >= 0; b--) begin
                v = pat[b];
                if (b == 0 && k == flip_k) v = ~v;
                tr.push_back({v, 1'(b == 0), 1'b1, 1'b0, 1'b0});
            end
            if (k < r.frames - 1)
                for (int g = 0; g < r.gap; g++) tr.push_back(5'b10100);
        end
        if (r.abort_at > 0)
            while (tr.size() > r.abort_at) void'(tr.pop_back());
        foreach (tr[i]) exp_q.push_back(tr[i]);
        exp_q.push_back(5'b10010);
        return tr.size();
    endfunction

    // Monitor: one comparison per cycle; an empty queue means the block should be idle.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] a;
        if (mon_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b10001;
            a = {ser_out, frame_strobe, busy, done, req_ready};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t out/strobe/busy/done/ready got %b required %b",
                         $time, a, e);
            end
        end
    end

    task automatic wait_hs(output bit ok);
        logic rdy;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout got no req_ready required accept within 64 cycles");
        end
    endtask

    task automatic run_req(input req_t r, input bit has_next, input req_t nx);
        bit ok;
        int len;
        req_frames = CNT_W'(r.frames);
        req_gap    = GAP_W'(r.gap);
        req_valid  = 1'b1;
        wait_hs(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        len       = build(r);
        req_valid = 1'b0;
        for (int c = 1; c <= len; c++) begin
            abort = (c == r.abort_at);
`ifdef SEQ_GEN_0001_ERRINJ_EN
            err_inj = (c == r.inj_at);
`endif
            if (c == 2 && r.early && has_next) begin
                req_frames = CNT_W'(nx.frames);
                req_gap    = GAP_W'(nx.gap);
                req_valid  = 1'b1;
            end
            @(posedge clk);
            #1;
            abort   = 1'b0;
            err_inj = 1'b0;
        end
    endtask

    initial begin
        req_t r;
        req_t dummy;
        bit   ok;
        int   len;
        n_tests    = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        abort      = 1'b0;
        err_inj    = 1'b0;
        req_frames = '0;
        req_gap    = '0;
        dummy      = '{0, 0, 0, 0, 1'b0};

        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        reqs.push_back('{1, 0, 0, 0, 1'b0});
        reqs.push_back('{3, 2, 0, 0, 1'b0});
        reqs.push_back('{0, 0, 0, 0, 1'b0});
        reqs.push_back('{5, 0, 6, 0, 1'b1});
        reqs.push_back('{2, 1, 0, 0, 1'b0});
        reqs.push_back('{2, 3, 7, 0, 1'b0});
`ifdef SEQ_GEN_0001_ERRINJ_EN
        reqs.push_back('{2, 0, 0, 1, 1'b0});
`endif
        for (int i = 0; i < 30; i++) begin
            r.frames   = int'($urandom_range(0, 4));
            r.gap      = int'($urandom_range(0, 3));
            len        = (r.frames > 0) ? r.frames * int'(PAT_W) + (r.frames - 1) * r.gap : 0;
            r.abort_at = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            r.inj_at   = 0;
`ifdef SEQ_GEN_0001_ERRINJ_EN
            if (r.abort_at == 0 && len >= 2 && $urandom_range(0, 1) == 1)
                r.inj_at = int'($urandom_range(1, len - 1));
`endif
            r.early = bit'($urandom_range(0, 1));
            reqs.push_back(r);
        end

        for (int i = 0; i < reqs.size(); i++) begin
            if (i + 1 < reqs.size()) run_req(reqs[i], 1'b1, reqs[i+1]);
            else                     run_req(reqs[i], 1'b0, dummy);
        end

        // Reset in the middle of a request: idle next cycle, no done pulse.
        @(posedge clk);
        #1;
        r = '{5, 1, 0, 0, 1'b0};
        req_frames = CNT_W'(r.frames);
        req_gap    = GAP_W'(r.gap);
        req_valid  = 1'b1;
        wait_hs(ok);
        if (ok) void'(build(r));
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
